imem_dbg_arbiter: RTL and testbench

- Shares the instruction RAM debug port (byte address A2, write data WD2, byte write enables WE2, read data RD2) between two requesters:
  - requester 0: debugger (UART/host debug shell);
  - requester 1: program loader (bulk image writer).
- Arbitrates, sequences each access through the synchronous BRAM read latency, and returns read data plus an acknowledge to the winner.
- Sits beside the IF-ID segment register. It does not touch fetch port A.

---
 rtl/imem_dbg_arbiter_if.sv | 41 ++++
 rtl/imem_dbg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_imem_dbg_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dbg_arbiter_if.sv
// Debug-port bundle between the two requesters (debugger, loader) and
// instruction RAM port B; the arbiter takes the slave view.
interface imem_dbg_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req0;
    logic [3:0]        we0;
    logic [ADDR_W-1:0] addr0;
    logic [31:0]       wdata0;
    logic              gnt0;
    logic              ack0;
    logic              err0;
    logic [31:0]       rdata0;

    logic              req1;
    logic [3:0]        we1;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata1;
    logic              gnt1;
    logic              ack1;
    logic              err1;
    logic [31:0]       rdata1;

    logic [31:0]       A2;
    logic [31:0]       WD2;
    logic [3:0]        WE2;
    logic [31:0]       RD2;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, RD2,
        output gnt0, ack0, err0, rdata0, gnt1, ack1, err1, rdata1,
               A2, WD2, WE2, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, RD2,
        input  gnt0, ack0, err0, rdata0, gnt1, ack1, err1, rdata1,
               A2, WD2, WE2, busy
    );
endinterface

// File: rtl/imem_dbg_arbiter.sv
// Two-requester arbiter for instruction RAM port B with registered outputs.
// Define IMEM_ARB_DBG_PRIO_EN for fixed debugger priority instead of round-robin.
module imem_dbg_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    imem_dbg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
`ifndef IMEM_ARB_DBG_PRIO_EN
    logic              rr_q, rr_d;
`endif
    logic [31:0]       a2_q, a2_d;
    logic [31:0]       wd2_q, wd2_d;
    logic [3:0]        we2_q, we2_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              busy_q, busy_d;

    logic              pick;
    logic [3:0]        sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    always_comb begin
`ifdef IMEM_ARB_DBG_PRIO_EN
        pick = ~bus.req0;
`else
        pick = (bus.req0 && bus.req1) ? ~rr_q : ~bus.req0;
`endif
        sel_we    = pick ? bus.we1    : bus.we0;
        sel_addr  = pick ? bus.addr1  : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        err_d    = err_q;
        wr_d     = wr_q;
`ifndef IMEM_ARB_DBG_PRIO_EN
        rr_d     = rr_q;
`endif
        a2_d     = a2_q;
        wd2_d    = wd2_q;
        we2_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win_d  = pick;
`ifndef IMEM_ARB_DBG_PRIO_EN
                    rr_d   = pick;
`endif
                    gnt0_d = ~pick;
                    gnt1_d = pick;
                    wr_d   = |sel_we;
                    cnt_d  = 2'(RD_LAT);
                    if (sel_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        a2_d    = 32'(sel_addr);
                        wd2_d   = sel_wdata;
                        we2_d   = sel_we;
                        state_d = ISSUE;
                    end
                end
            end
            // Counter is loaded with RD_LAT, so every access spends RD_LAT
            // cycles in WAIT before DONE samples RD2 (ack lands RD_LAT+2 after gnt).
            ISSUE: state_d = (cnt_q != 2'd0) ? WAIT : DONE;
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = DONE;
            end
            DONE: begin
                if (!err_q && !wr_q) begin
                    if (win_q) rdata1_d = bus.RD2;
                    else       rdata0_d = bus.RD2;
                end
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                err0_d  = ~win_q & err_q;
                err1_d  = win_q & err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
`ifndef IMEM_ARB_DBG_PRIO_EN
            rr_q     <= 1'b1;
`endif
            a2_q     <= '0;
            wd2_q    <= '0;
            we2_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
`ifndef IMEM_ARB_DBG_PRIO_EN
            rr_q     <= rr_d;
`endif
            a2_q     <= a2_d;
            wd2_q    <= wd2_d;
            we2_q    <= we2_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.A2     = a2_q;
    assign bus.WD2    = wd2_q;
    assign bus.WE2    = we2_q;
    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.err0   = err0_q;
    assign bus.err1   = err1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_imem_dbg_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1 and one at RD_LAT=3, each with a BRAM model.
module tb_imem_dbg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imem_dbg_arbiter_if #(.ADDR_W(32)) bus1 ();
    imem_dbg_arbiter_if #(.ADDR_W(32)) bus3 ();

    imem_dbg_arbiter #(.RD_LAT(1), .ADDR_W(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    imem_dbg_arbiter #(.RD_LAT(3), .ADDR_W(32)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // BRAM models: contents reload while rst is high.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem1[i] <= '0;
            mem1[16] <= 32'hDEADBEEF;
            mem1[2]  <= 32'hFFFFFFFF;
            mem1[3]  <= 32'hA5A5A5A5;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus1.WE2[b]) mem1[bus1.A2[7:2]][8*b +: 8] <= bus1.WD2[8*b +: 8];
        end
        bus1.RD2 <= mem1[bus1.A2[7:2]];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem3[i] <= '0;
            mem3[5] <= 32'hCAFEF00D;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus3.WE2[b]) mem3[bus3.A2[7:2]][8*b +: 8] <= bus3.WD2[8*b +: 8];
        end
        p0       <= mem3[bus3.A2[7:2]];
        p1       <= p0;
        bus3.RD2 <= p1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus1.req0 = 0; bus1.we0 = '0; bus1.addr0 = '0; bus1.wdata0 = '0;
        bus1.req1 = 0; bus1.we1 = '0; bus1.addr1 = '0; bus1.wdata1 = '0;
        bus3.req0 = 0; bus3.we0 = '0; bus3.addr0 = '0; bus3.wdata0 = '0;
        bus3.req1 = 0; bus3.we1 = '0; bus3.addr1 = '0; bus3.wdata1 = '0;
        tick; tick;
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus1.busy); end
        checks++; if (bus1.WE2 !== 4'h0) begin errors++; $display("FAIL rst_we2: got %h want 0", bus1.WE2); end
        checks++; if (bus1.A2 !== 32'h0 || bus1.WD2 !== 32'h0) begin errors++; $display("FAIL rst_a2_wd2: got %h %h want 0 0", bus1.A2, bus1.WD2); end
        checks++; if ({bus1.gnt0, bus1.gnt1, bus1.ack0, bus1.ack1, bus1.err0, bus1.err1} !== 6'b0) begin
            errors++; $display("FAIL rst_pulses: got %b want 000000", {bus1.gnt0, bus1.gnt1, bus1.ack0, bus1.ack1, bus1.err0, bus1.err1}); end
        checks++; if (bus1.rdata0 !== 32'h0 || bus1.rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h want 0 0", bus1.rdata0, bus1.rdata1); end
        #2 rst = 1'b0;
        tick;
        checks++; if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b %b want 0 0", bus1.busy, bus3.busy); end
    endtask

    task automatic test_single_read;
        bus1.req0 = 1; bus1.we0 = 4'h0; bus1.addr0 = 32'h40;
        tick;
        checks++; if (bus1.gnt0 !== 1'b1 || bus1.gnt1 !== 1'b0) begin errors++; $display("FAIL rd_gnt: got gnt0=%b gnt1=%b want 1 0", bus1.gnt0, bus1.gnt1); end
        checks++; if (bus1.A2 !== 32'h40 || bus1.WE2 !== 4'h0) begin errors++; $display("FAIL rd_a2_we2: got %h %h want 40 0", bus1.A2, bus1.WE2); end
        bus1.req0 = 0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            if (k < 3) begin
                checks++; if (bus1.ack0 !== 1'b0 || bus1.busy !== 1'b1) begin errors++; $display("FAIL rd_inflight%0d: got ack0=%b busy=%b want 0 1", k, bus1.ack0, bus1.busy); end
            end
        end
        checks++; if (bus1.ack0 !== 1'b1 || bus1.err0 !== 1'b0) begin errors++; $display("FAIL rd_ack: got ack0=%b err0=%b want 1 0", bus1.ack0, bus1.err0); end
        checks++; if (bus1.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", bus1.rdata0); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_at_ack: got %b want 0", bus1.busy); end
    endtask

    task automatic test_write_readback;
        bus1.req1 = 1; bus1.we1 = 4'b0011; bus1.addr1 = 32'h8; bus1.wdata1 = 32'h12345678;
        tick;
        checks++; if (bus1.gnt1 !== 1'b1) begin errors++; $display("FAIL wr_gnt1: got %b want 1", bus1.gnt1); end
        checks++; if (bus1.WE2 !== 4'b0011 || bus1.WD2 !== 32'h12345678 || bus1.A2 !== 32'h8) begin
            errors++; $display("FAIL wr_issue: got we=%b wd=%h a=%h want 0011 12345678 8", bus1.WE2, bus1.WD2, bus1.A2); end
        bus1.req1 = 0;
        tick;
        checks++; if (bus1.WE2 !== 4'h0) begin errors++; $display("FAIL wr_we2_width: got %b want 0000", bus1.WE2); end
        tick; tick;
        checks++; if (bus1.ack1 !== 1'b1 || bus1.err1 !== 1'b0) begin errors++; $display("FAIL wr_ack1: got ack1=%b err1=%b want 1 0", bus1.ack1, bus1.err1); end
        checks++; if (bus1.rdata1 !== 32'h0) begin errors++; $display("FAIL wr_rdata_hold: got %h want 0", bus1.rdata1); end
        checks++; if (mem1[2] !== 32'hFFFF5678) begin errors++; $display("FAIL wr_mem: got %h want ffff5678", mem1[2]); end
        bus1.req1 = 1; bus1.we1 = 4'h0; bus1.addr1 = 32'h8;
        tick;
        checks++; if (bus1.gnt1 !== 1'b1) begin errors++; $display("FAIL rb_gnt1: got %b want 1", bus1.gnt1); end
        bus1.req1 = 0;
        tick; tick; tick;
        checks++; if (bus1.ack1 !== 1'b1 || bus1.rdata1 !== 32'hFFFF5678) begin
            errors++; $display("FAIL rb_data: got ack1=%b rdata1=%h want 1 ffff5678", bus1.ack1, bus1.rdata1); end
        checks++; if (bus1.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rb_rdata0_hold: got %h want deadbeef", bus1.rdata0); end
    endtask

    task automatic test_contention;
        logic        exp_order [4];
        logic [31:0] exp_rd1;
        int          ng = 0;
        int          last_g = 0;
`ifdef IMEM_ARB_DBG_PRIO_EN
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`else
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
        exp_rd1 = 32'hFFFF5678;
        bus1.req0 = 1; bus1.we0 = 4'h0; bus1.addr0 = 32'h40;
        bus1.req1 = 1; bus1.we1 = 4'h0; bus1.addr1 = 32'hC;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick;
            if (bus1.gnt0 || bus1.gnt1) begin
                checks++;
                if (ng >= 4) begin
                    errors++; $display("FAIL ct_extra_gnt: got grant at cycle %0d want none", cyc);
                end else if (bus1.gnt1 !== exp_order[ng] || bus1.gnt0 === bus1.gnt1) begin
                    errors++; $display("FAIL ct_order%0d: got gnt0=%b gnt1=%b want gnt1=%b", ng, bus1.gnt0, bus1.gnt1, exp_order[ng]);
                end
                if (ng > 0) begin
                    checks++; if (cyc - last_g != 4) begin errors++; $display("FAIL ct_spacing%0d: got %0d want 4", ng, cyc - last_g); end
                end
                last_g = cyc;
                ng++;
            end
            if (bus1.ack0) begin
                checks++; if (bus1.rdata1 !== exp_rd1 || bus1.rdata0 !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL ct_ack0_data: got rdata0=%h rdata1=%h want deadbeef %h", bus1.rdata0, bus1.rdata1, exp_rd1); end
            end
            if (bus1.ack1) begin
                exp_rd1 = 32'hA5A5A5A5;
                checks++; if (bus1.rdata1 !== exp_rd1) begin errors++; $display("FAIL ct_ack1_data: got %h want a5a5a5a5", bus1.rdata1); end
            end
            if (ng >= 4) begin bus1.req0 = 0; bus1.req1 = 0; end
        end
        checks++; if (ng != 4) begin errors++; $display("FAIL ct_count: got %0d grants want 4", ng); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL ct_drain: got busy=%b want 0", bus1.busy); end
    endtask

    task automatic test_misaligned;
        bit gnt_seen = 0;
        bit ack_seen = 0;
        bit we_seen  = 0;
        bus1.req0 = 1; bus1.we0 = 4'hF; bus1.addr0 = 32'h42; bus1.wdata0 = 32'h0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick;
            if (bus1.WE2 !== 4'h0) we_seen = 1;
            if (bus1.gnt0) begin gnt_seen = 1; bus1.req0 = 0; end
            if (bus1.ack0) begin
                ack_seen = 1;
                checks++; if (bus1.err0 !== 1'b1) begin errors++; $display("FAIL mis_err0: got %b want 1", bus1.err0); end
            end
        end
        bus1.req0 = 0;
        checks++; if (!gnt_seen) begin errors++; $display("FAIL mis_gnt: got no gnt0 want gnt0"); end
        checks++; if (!ack_seen) begin errors++; $display("FAIL mis_ack: got no ack0 want ack0"); end
        checks++; if (we_seen) begin errors++; $display("FAIL mis_we2: got nonzero WE2 want 0"); end
        checks++; if (mem1[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem: got %h want deadbeef", mem1[16]); end
        checks++; if (bus1.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_rdata0: got %h want deadbeef", bus1.rdata0); end
    endtask

    task automatic test_latency3;
        bus3.req0 = 1; bus3.we0 = 4'h0; bus3.addr0 = 32'h14;
        tick;
        checks++; if (bus3.gnt0 !== 1'b1) begin errors++; $display("FAIL l3_gnt: got %b want 1", bus3.gnt0); end
        bus3.req0 = 0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k < 5) begin
                checks++; if (bus3.busy !== 1'b1 || bus3.ack0 !== 1'b0) begin errors++; $display("FAIL l3_cycle%0d: got busy=%b ack0=%b want 1 0", k, bus3.busy, bus3.ack0); end
            end
        end
        checks++; if (bus3.ack0 !== 1'b1 || bus3.busy !== 1'b0) begin errors++; $display("FAIL l3_ack: got ack0=%b busy=%b want 1 0", bus3.ack0, bus3.busy); end
        checks++; if (bus3.rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_data: got %h want cafef00d", bus3.rdata0); end
    endtask

    task automatic test_reset_mid_access;
        bit stray_ack = 0;
        bus1.req0 = 1; bus1.we0 = 4'h0; bus1.addr0 = 32'h40;
        tick;
        checks++; if (bus1.gnt0 !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", bus1.gnt0); end
        bus1.req0 = 0;
        tick;
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus1.busy, bus1.WE2, bus1.gnt0, bus1.gnt1, bus1.ack0, bus1.ack1} !== 9'b0) begin
            errors++; $display("FAIL rm_async: got busy=%b we2=%b gnt=%b%b ack=%b%b want all 0",
                               bus1.busy, bus1.WE2, bus1.gnt0, bus1.gnt1, bus1.ack0, bus1.ack1); end
        tick;
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (bus1.ack0 || bus1.ack1) stray_ack = 1;
        end
        checks++; if (stray_ack) begin errors++; $display("FAIL rm_no_ack: got ack after reset want none"); end
        bus1.req0 = 1; bus1.req1 = 1; bus1.we1 = 4'h0; bus1.addr1 = 32'hC;
        tick;
        checks++; if (bus1.gnt0 !== 1'b1 || bus1.gnt1 !== 1'b0) begin errors++; $display("FAIL rm_rr_start: got gnt0=%b gnt1=%b want 1 0", bus1.gnt0, bus1.gnt1); end
        bus1.req0 = 0; bus1.req1 = 0;
        tick; tick; tick;
        checks++; if (bus1.ack0 !== 1'b1 || bus1.rdata0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rm_read: got ack0=%b rdata0=%h want 1 deadbeef", bus1.ack0, bus1.rdata0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_read;
        test_write_readback;
        test_contention;
        test_misaligned;
        test_latency3;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
